// File: rtl/stopwatch_lap_ctrl_pkg.sv
// stopwatch_pkg: shared state encoding and key bit positions for the stopwatch controller.
package stopwatch_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        RUN    = 3'b001,
        FREEZE = 3'b011,
        PAUSE  = 3'b010,
        RECALL = 3'b110
    } state_t;
    localparam int KEY_RST   = 0;
    localparam int KEY_SPLIT = 1;
    localparam int KEY_PAUSE = 2;
    localparam int KEY_LAP   = 3;
endpackage

// File: rtl/stopwatch_lap_ctrl_if.sv
// stopwatch_lap_ctrl_if: key/time inputs and counter, display and lap outputs of the controller.
interface stopwatch_lap_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int W     = 16
);
    import stopwatch_pkg::*;
    logic [3:0]               keys;
    logic [W-1:0]             time_bcd;
    logic                     cnt_reset;
    logic                     cnt_enable;
    logic                     freeze;
    logic                     disp_sel;
    logic [W-1:0]             lap_data;
    logic [$clog2(DEPTH)-1:0] lap_idx;
    logic [$clog2(DEPTH):0]   lap_count;
    logic                     lap_full;
    modport master (
        output keys, time_bcd,
        input  cnt_reset, cnt_enable, freeze, disp_sel, lap_data, lap_idx, lap_count, lap_full
    );
    modport slave (
        input  keys, time_bcd,
        output cnt_reset, cnt_enable, freeze, disp_sel, lap_data, lap_idx, lap_count, lap_full
    );
endinterface

// File: rtl/stopwatch_lap_ctrl_lap_buffer.sv
// lap_buffer: DEPTH x W lap store with fill count, recall index and registered read port.
// Present only when STOPWATCH_LAP_MEMORY_EN is defined.
`ifdef STOPWATCH_LAP_MEMORY_EN
module lap_buffer
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    parameter int IW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr,
    input  logic          start,
    input  logic          step,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [IW-1:0] idx,
    output logic [CW-1:0] count,
    output logic          full
);
    logic [W-1:0] mem [DEPTH];
    logic         wr_ok;
    logic         last;
    assign full  = count == CW'(DEPTH);
    assign wr_ok = wr && !full;
    assign last  = CW'(idx) == count - CW'(1);
    always_ff @(posedge clk) begin
        if (wr_ok) mem[count[IW-1:0]] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            idx   <= '0;
            dout  <= '0;
        end else begin
            count <= clr ? '0 : wr_ok ? count + CW'(1) : count;
            idx   <= (clr || start || (step && last)) ? '0 : step ? idx + IW'(1) : idx;
            dout  <= mem[idx];
        end
    end
endmodule
`endif

// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl: key-driven stopwatch sequencer (counter reset/enable, display freeze).
// Lap capture/recall is built only when STOPWATCH_LAP_MEMORY_EN is defined.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input logic clk,
    input logic rst,
    stopwatch_lap_ctrl_if.slave bus
);
    state_t state, nxt, ret, ret_nxt;
    logic   k_rst, k_split, k_pause, k_lap, go, has_laps, enter;
    always_comb begin
        k_rst    = bus.keys[KEY_RST];
        k_split  = !k_rst && bus.keys[KEY_SPLIT];
        k_pause  = !k_rst && !bus.keys[KEY_SPLIT] && bus.keys[KEY_PAUSE];
        k_lap    = bus.keys[KEY_LAP] && !(|bus.keys[KEY_PAUSE:KEY_RST]);
        go       = k_split || k_pause;
        has_laps = bus.lap_count != '0;
        nxt      = state;
        if (k_rst) nxt = IDLE;
        else
            case (state)
                IDLE:    nxt = go ? RUN : (k_lap && has_laps) ? RECALL : IDLE;
                RUN:     nxt = k_split ? FREEZE : k_pause ? PAUSE : RUN;
                FREEZE:  nxt = go ? RUN : FREEZE;
                PAUSE:   nxt = go ? RUN : (k_lap && has_laps) ? RECALL : PAUSE;
                RECALL:  nxt = k_split ? RUN : k_pause ? ret : RECALL;
                default: nxt = IDLE;
            endcase
        enter   = nxt == RECALL && state != RECALL;
        ret_nxt = enter ? state : ret;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ret   <= IDLE;
        end else begin
            state <= nxt;
            ret   <= ret_nxt;
        end
    end
    assign bus.cnt_reset  = state == IDLE;
    assign bus.cnt_enable = state == RUN || state == FREEZE;
    assign bus.freeze     = state == FREEZE || state == RECALL;
`ifdef STOPWATCH_LAP_MEMORY_EN
    lap_buffer #(.DEPTH(DEPTH), .W(W)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (k_rst),
        .wr    (state == RUN && k_lap),
        .start (enter),
        .step  (state == RECALL && k_lap),
        .din   (bus.time_bcd),
        .dout  (bus.lap_data),
        .idx   (bus.lap_idx),
        .count (bus.lap_count),
        .full  (bus.lap_full)
    );
    assign bus.disp_sel = state == RECALL;
`else
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    assign bus.disp_sel  = 1'b0;
    assign bus.lap_data  = W'(0);
    assign bus.lap_idx   = IW'(0);
    assign bus.lap_count = CW'(0);
    assign bus.lap_full  = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb_stopwatch_lap_ctrl: directed plus random key stimulus against a behavioural stopwatch model.
// Follows STOPWATCH_LAP_MEMORY_EN so both builds are checked.
module tb_stopwatch_lap_ctrl;
    localparam int DEPTH = 4;
    localparam int W     = 16;
`ifdef STOPWATCH_LAP_MEMORY_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    stopwatch_lap_ctrl_if #(.DEPTH(DEPTH), .W(W)) bus ();
    stopwatch_lap_ctrl #(.DEPTH(DEPTH), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef enum {M_IDLE, M_RUN, M_FREEZE, M_PAUSE, M_RECALL} mode_t;
    mode_t        m = M_IDLE;
    mode_t        m_ret = M_IDLE;
    logic [W-1:0] laps[$];
    int           ridx = 0;
    logic [W-1:0] ld = '0;
    bit           ld_known = 1'b0;
    int           tests = 0;
    int           fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic [3:0] k, input logic [W-1:0] t, input logic r);
        if (r) begin
            m = M_IDLE; m_ret = M_IDLE; laps.delete(); ridx = 0; ld = '0; ld_known = 1'b1;
            return;
        end
        if (LAP_EN) begin
            ld_known = ridx < laps.size();
            if (ld_known) ld = laps[ridx];
        end else begin
            ld = '0; ld_known = 1'b1;
        end
        if (k[0]) begin
            m = M_IDLE; laps.delete(); ridx = 0;
        end else if (k[1]) begin
            m = (m == M_RUN) ? M_FREEZE : M_RUN;
        end else if (k[2]) begin
            if (m == M_RUN) m = M_PAUSE;
            else if (m == M_RECALL) m = m_ret;
            else m = M_RUN;
        end else if (k[3] && LAP_EN) begin
            if (m == M_RUN) begin
                if (laps.size() < DEPTH) laps.push_back(t);
            end else if ((m == M_IDLE || m == M_PAUSE) && laps.size() > 0) begin
                m_ret = m; m = M_RECALL; ridx = 0;
            end else if (m == M_RECALL) begin
                ridx = (ridx + 1) % laps.size();
            end
        end
    endtask

    task automatic compare();
        check("cnt_reset", 32'(bus.cnt_reset), 32'(m == M_IDLE));
        check("cnt_enable", 32'(bus.cnt_enable), 32'(m == M_RUN || m == M_FREEZE));
        check("freeze", 32'(bus.freeze), 32'(m == M_FREEZE || m == M_RECALL));
        check("disp_sel", 32'(bus.disp_sel), 32'(m == M_RECALL));
        check("lap_count", 32'(bus.lap_count), 32'(laps.size()));
        check("lap_full", 32'(bus.lap_full), 32'(laps.size() == DEPTH));
        check("lap_idx", 32'(bus.lap_idx), 32'(ridx));
        if (ld_known) check("lap_data", 32'(bus.lap_data), 32'(ld));
    endtask

    task automatic cycle(input logic [3:0] k, input logic [W-1:0] t, input logic r);
        bus.keys = k; bus.time_bcd = t; rst = r;
        @(posedge clk);
        model(k, t, r);
        @(negedge clk);
        compare();
    endtask

    logic [3:0] kr;
    initial begin
        bus.keys = '0; bus.time_bcd = '0; rst = 1'b1;
        cycle(4'b0000, 16'h0000, 1'b1);
        cycle(4'b0010, 16'h0000, 1'b0);
        cycle(4'b0010, 16'h0000, 1'b0);
        cycle(4'b0010, 16'h0000, 1'b0);
        cycle(4'b0110, 16'h0000, 1'b0);
        cycle(4'b0001, 16'h0000, 1'b0);
        cycle(4'b0010, 16'h0000, 1'b0);
        cycle(4'b1000, 16'h0012, 1'b0);
        cycle(4'b1000, 16'h0034, 1'b0);
        cycle(4'b1000, 16'h0056, 1'b0);
        cycle(4'b1000, 16'h0078, 1'b0);
        cycle(4'b1000, 16'h0099, 1'b0);
        cycle(4'b0100, 16'h0000, 1'b0);
        cycle(4'b1000, 16'h0000, 1'b0);
        cycle(4'b0000, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(4'b1000, 16'h0000, 1'b0);
            cycle(4'b0000, 16'h0000, 1'b0);
        end
        cycle(4'b0100, 16'h0000, 1'b0);
        cycle(4'b0001, 16'h0000, 1'b0);
        cycle(4'b1000, 16'h0000, 1'b0);
        cycle(4'b0010, 16'h0000, 1'b0);
        cycle(4'b1000, 16'h1234, 1'b0);
        cycle(4'b0100, 16'h0000, 1'b0);
        cycle(4'b1000, 16'h0000, 1'b0);
        cycle(4'b1000, 16'h0000, 1'b0);
        cycle(4'b0000, 16'h0000, 1'b0);
        cycle(4'b1000, 16'h0000, 1'b1);
        cycle(4'b0000, 16'h0000, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            kr = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            if (kr[0] && $urandom_range(0, 9) != 0) kr[0] = 1'b0;
            if ($urandom_range(0, 3) == 0) kr = '0;
            cycle(kr, 16'($urandom), $urandom_range(0, 99) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
